// File: rtl/reg_cnt_rstp_pkg.sv
// Shared types and the saturate/wrap next-count rule for the multi-channel
// stop/block event counter.
package reg_cnt_rstp_pkg;

   localparam int CNT_MAX_W = 32;

   typedef enum logic {
      CNT_SAT,
      CNT_WRAP
   } cnt_mode_e;

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_INC,
      OP_DEC
   } cnt_op_e;

   // Works on a widened count; max is the channel's all-ones value.
   function automatic logic [CNT_MAX_W-1:0] next_cnt(
      input logic [CNT_MAX_W-1:0] cnt,
      input logic [CNT_MAX_W-1:0] max,
      input cnt_op_e              op,
      input cnt_mode_e            mode
   );
      logic [CNT_MAX_W-1:0] res;
      res = cnt;
      case (op)
         OP_INC:  res = (cnt == max) ? ((mode == CNT_WRAP) ? '0 : max) : cnt + 1;
         OP_DEC:  res = (cnt == '0) ? ((mode == CNT_WRAP) ? max : '0) : cnt - 1;
         default: res = cnt;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/reg_cnt_rstp_chan.sv
// One counter channel: stop/block decode, count register, sticky over/underflow
// and the combinational zero/threshold flags.
module reg_cnt_rstp_chan
   import reg_cnt_rstp_pkg::*;
#(
   parameter int        BIT_W   = 5,
   parameter int        THR     = 16,
   parameter int        RST_VAL = 0,
   parameter cnt_mode_e MODE    = CNT_SAT
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             som_i,
   input  logic             stop_i,
   input  logic             blkf_i,
   input  logic             clr_i,
   input  logic             ld_i,
   input  logic [BIT_W-1:0] ld_val_i,
   output logic [BIT_W-1:0] cnt_o,
   output logic             zero_o,
   output logic             thr_o,
   output logic             ovf_o,
   output logic             udf_o
);

   localparam logic [BIT_W-1:0] MAX = '1;

   logic    inc;
   logic    dec;
   cnt_op_e op;

   // A stop without start-of-measure cancels the block-flag decrement.
   assign inc = en_i & som_i & stop_i;
   assign dec = en_i & blkf_i & ~(~som_i & stop_i);
   assign op  = (inc && !dec) ? OP_INC : (dec && !inc) ? OP_DEC : OP_HOLD;

   // NOTE: state is written with non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_o <= BIT_W'(RST_VAL);
         ovf_o <= 1'b0;
         udf_o <= 1'b0;
      end else if (clr_i) begin
         cnt_o <= '0;
         ovf_o <= 1'b0;
         udf_o <= 1'b0;
      end else if (ld_i) begin
         cnt_o <= ld_val_i;
      end else begin
         cnt_o <= BIT_W'(next_cnt(CNT_MAX_W'(cnt_o), CNT_MAX_W'(MAX), op, MODE));
         if (op == OP_INC && cnt_o == MAX) ovf_o <= 1'b1;
         if (op == OP_DEC && cnt_o == '0)  udf_o <= 1'b1;
      end
   end

   assign zero_o = (cnt_o == '0);
   assign thr_o  = (cnt_o >= BIT_W'(THR));

endmodule

// File: rtl/reg_cnt_rstp_multi.sv
// Multi-channel stop/block event counter: per-channel counters, load decode,
// flag concatenation and a registered readback port.
module reg_cnt_rstp_multi
   import reg_cnt_rstp_pkg::*;
#(
   parameter  int BIT_W   = 5,
   parameter  int NCH     = 4,
   parameter  int WRAP    = 0,
   parameter  int THR     = 16,
   parameter  int RST_VAL = 0,
   localparam int SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic [NCH-1:0]       som_i,
   input  logic [NCH-1:0]       stop_i,
   input  logic [NCH-1:0]       blkf_i,
   input  logic [NCH-1:0]       clr_i,
   input  logic                 ld_i,
   input  logic [SEL_W-1:0]     ld_sel_i,
   input  logic [BIT_W-1:0]     ld_val_i,
   input  logic [SEL_W-1:0]     rd_sel_i,
   output logic [NCH*BIT_W-1:0] cnt_o,
   output logic [BIT_W-1:0]     rd_data_o,
   output logic [NCH-1:0]       zero_o,
   output logic [NCH-1:0]       thr_o,
   output logic [NCH-1:0]       ovf_o,
   output logic [NCH-1:0]       udf_o
);

   localparam cnt_mode_e MODE = (WRAP != 0) ? CNT_WRAP : CNT_SAT;

   logic [BIT_W-1:0] cnt_arr [NCH];
   logic [BIT_W-1:0] rd_mux;

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      logic ld_hit;

      // Out-of-range selects never match a channel, so such loads are dropped.
      assign ld_hit = ld_i && (int'(ld_sel_i) == c);

      reg_cnt_rstp_chan #(
         .BIT_W   (BIT_W),
         .THR     (THR),
         .RST_VAL (RST_VAL),
         .MODE    (MODE)
      ) u_chan (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .en_i     (en_i),
         .som_i    (som_i[c]),
         .stop_i   (stop_i[c]),
         .blkf_i   (blkf_i[c]),
         .clr_i    (clr_i[c]),
         .ld_i     (ld_hit),
         .ld_val_i (ld_val_i),
         .cnt_o    (cnt_arr[c]),
         .zero_o   (zero_o[c]),
         .thr_o    (thr_o[c]),
         .ovf_o    (ovf_o[c]),
         .udf_o    (udf_o[c])
      );

      assign cnt_o[c*BIT_W +: BIT_W] = cnt_arr[c];
   end

   // NOTE: the default assignment up front keeps this mux from inferring a
   // latch and makes unmatched selects read back as zero.
   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < NCH; c++) begin
         if (int'(rd_sel_i) == c) rd_mux = cnt_arr[c];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rd_data_o <= '0;
      else         rd_data_o <= rd_mux;
   end

endmodule

// File: tb/tb_reg_cnt_rstp_multi.sv
// Directed bench: saturating 4-channel counter (table plus hand sequences) and
// a 3-channel wrapping counter for wrap and out-of-range select cases.
module tb_reg_cnt_rstp_multi;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Saturating DUT, 4 channels
   logic        en;
   logic [3:0]  som, stop, blkf, clr;
   logic        ld;
   logic [1:0]  ld_sel, rd_sel;
   logic [4:0]  ld_val;
   logic [19:0] cnt;
   logic [4:0]  rd_data;
   logic [3:0]  zero, thr, ovf, udf;

   // Wrapping DUT, 3 channels
   logic        w_en;
   logic [2:0]  w_som, w_stop, w_blkf, w_clr;
   logic        w_ld;
   logic [1:0]  w_ld_sel, w_rd_sel;
   logic [4:0]  w_ld_val;
   logic [14:0] w_cnt;
   logic [4:0]  w_rd_data;
   logic [2:0]  w_zero, w_thr, w_ovf, w_udf;

   int checks = 0;
   int errors = 0;

   reg_cnt_rstp_multi #(
      .BIT_W(5), .NCH(4), .WRAP(0), .THR(16), .RST_VAL(0)
   ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .som_i(som), .stop_i(stop),
      .blkf_i(blkf), .clr_i(clr), .ld_i(ld), .ld_sel_i(ld_sel),
      .ld_val_i(ld_val), .rd_sel_i(rd_sel), .cnt_o(cnt), .rd_data_o(rd_data),
      .zero_o(zero), .thr_o(thr), .ovf_o(ovf), .udf_o(udf)
   );

   reg_cnt_rstp_multi #(
      .BIT_W(5), .NCH(3), .WRAP(1), .THR(16), .RST_VAL(0)
   ) u_wrap (
      .clk_i(clk), .rst_ni(rst_n), .en_i(w_en), .som_i(w_som), .stop_i(w_stop),
      .blkf_i(w_blkf), .clr_i(w_clr), .ld_i(w_ld), .ld_sel_i(w_ld_sel),
      .ld_val_i(w_ld_val), .rd_sel_i(w_rd_sel), .cnt_o(w_cnt),
      .rd_data_o(w_rd_data), .zero_o(w_zero), .thr_o(w_thr), .ovf_o(w_ovf),
      .udf_o(w_udf)
   );

   typedef struct {
      logic        en;
      logic [3:0]  som, stop, blkf, clr;
      logic        ld;
      logic [1:0]  ld_sel;
      logic [4:0]  ld_val;
      logic [19:0] exp_cnt;
      logic [3:0]  exp_ovf, exp_udf;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en = 1'b1; som = '0; stop = '0; blkf = '0; clr = '0;
      ld = 1'b0; ld_sel = '0; ld_val = '0;
   endtask

   task automatic w_idle();
      w_en = 1'b1; w_som = '0; w_stop = '0; w_blkf = '0; w_clr = '0;
      w_ld = 1'b0; w_ld_sel = '0; w_ld_val = '0;
   endtask

   // Derive zero/threshold expectations from the expected counts
   task automatic check_flags(input string name, input logic [19:0] exp_cnt);
      logic [3:0] ez, et;
      for (int c = 0; c < 4; c++) begin
         ez[c] = (exp_cnt[c*5 +: 5] == 5'd0);
         et[c] = (exp_cnt[c*5 +: 5] >= 5'd16);
      end
      check({name, " zero"}, 32'(zero), 32'(ez));
      check({name, " thr"},  32'(thr),  32'(et));
   endtask

   initial begin
      //            en    som   stop  blkf  clr   ld    sel   val     ch3   ch2    ch1    ch0     ovf   udf
      vecs[0]  = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd0,  5'd1}, 4'h0, 4'h0};
      vecs[1]  = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd0,  5'd2}, 4'h0, 4'h0};
      vecs[2]  = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd0,  5'd3}, 4'h0, 4'h0};
      vecs[3]  = '{1'b1, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd0,  5'd3}, 4'h0, 4'h0};
      vecs[4]  = '{1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd0,  5'd3}, 4'h0, 4'h0};
      vecs[5]  = '{1'b1, 4'h0, 4'h0, 4'h1, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd0,  5'd2}, 4'h0, 4'h0};
      vecs[6]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 2'd1, 5'd31, {5'd0, 5'd0,  5'd31, 5'd2}, 4'h0, 4'h0};
      vecs[7]  = '{1'b1, 4'h2, 4'h2, 4'h0, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd31, 5'd2}, 4'h2, 4'h0};
      vecs[8]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h2, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd0,  5'd2}, 4'h0, 4'h0};
      vecs[9]  = '{1'b1, 4'h0, 4'h0, 4'h2, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd0,  5'd2}, 4'h0, 4'h2};
      vecs[10] = '{1'b1, 4'h8, 4'h8, 4'h0, 4'h8, 1'b1, 2'd3, 5'd9,  {5'd0, 5'd0,  5'd0,  5'd2}, 4'h0, 4'h2};
      vecs[11] = '{1'b0, 4'h8, 4'h8, 4'h1, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd0, 5'd0,  5'd0,  5'd2}, 4'h0, 4'h2};
      vecs[12] = '{1'b0, 4'h8, 4'h8, 4'h0, 4'h0, 1'b1, 2'd3, 5'd9,  {5'd9, 5'd0,  5'd0,  5'd2}, 4'h0, 4'h2};
      vecs[13] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 2'd2, 5'd15, {5'd9, 5'd15, 5'd0,  5'd2}, 4'h0, 4'h2};
      vecs[14] = '{1'b1, 4'h4, 4'h4, 4'h0, 4'h0, 1'b0, 2'd0, 5'd0,  {5'd9, 5'd16, 5'd0,  5'd2}, 4'h0, 4'h2};

      rst_n = 1'b0;
      idle();
      w_idle();
      rd_sel = 2'd0;
      w_rd_sel = 2'd0;

      // Reset state
      #3;
      check("rst cnt",  32'(cnt),     32'h0);
      check("rst zero", 32'(zero),    32'hF);
      check("rst thr",  32'(thr),     32'h0);
      check("rst ovf",  32'(ovf),     32'h0);
      check("rst udf",  32'(udf),     32'h0);
      check("rst rd",   32'(rd_data), 32'h0);
      #9;
      rst_n = 1'b1;

      // Table-driven decode, saturate, priority and enable vectors
      for (int i = 0; i < NVEC; i++) begin
         en = vecs[i].en; som = vecs[i].som; stop = vecs[i].stop;
         blkf = vecs[i].blkf; clr = vecs[i].clr; ld = vecs[i].ld;
         ld_sel = vecs[i].ld_sel; ld_val = vecs[i].ld_val;
         step();
         check($sformatf("vec%0d cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
         check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
         check($sformatf("vec%0d udf", i), 32'(udf), 32'(vecs[i].exp_udf));
         check_flags($sformatf("vec%0d", i), vecs[i].exp_cnt);
      end

      // Readback latency and pre-update value
      idle();
      rd_sel = 2'd2;
      step();
      check("rd ch2", 32'(rd_data), 32'd16);
      som = 4'h4; stop = 4'h4;
      step();
      check("rd pre-update", 32'(rd_data), 32'd16);
      check("cnt ch2 17", 32'(cnt[10 +: 5]), 32'd17);
      idle();
      step();
      check("rd post-update", 32'(rd_data), 32'd17);

      // Mid-count async reset with ch0 = 7
      rd_sel = 2'd0;
      ld = 1'b1; ld_sel = 2'd0; ld_val = 5'd7;
      step();
      check("rd before ld", 32'(rd_data), 32'd2);
      check("ld ch0 7", 32'(cnt[4:0]), 32'd7);
      idle();
      step();
      check("rd ch0 7", 32'(rd_data), 32'd7);
      som = 4'h1; stop = 4'h1;
      #3;
      rst_n = 1'b0;
      #1;
      check("mid rst cnt",  32'(cnt),     32'h0);
      check("mid rst zero", 32'(zero),    32'hF);
      check("mid rst ovf",  32'(ovf),     32'h0);
      check("mid rst udf",  32'(udf),     32'h0);
      check("mid rst rd",   32'(rd_data), 32'h0);
      #1;
      rst_n = 1'b1;
      step();
      check("first edge inc", 32'(cnt), 32'h1);
      idle();

      // Wrap mode, out-of-range load and readback select
      w_ld = 1'b1; w_ld_sel = 2'd2; w_ld_val = 5'd31;
      step();
      check("w ld 31", 32'(w_cnt), {17'd0, 5'd31, 5'd0, 5'd0});
      w_idle();
      w_som = 3'h4; w_stop = 3'h4;
      step();
      check("w wrap up cnt", 32'(w_cnt), 32'h0);
      check("w wrap up ovf", 32'(w_ovf), 32'h4);
      check("w wrap up udf", 32'(w_udf), 32'h0);
      w_idle();
      w_blkf = 3'h4;
      step();
      check("w wrap dn cnt", 32'(w_cnt), {17'd0, 5'd31, 5'd0, 5'd0});
      check("w wrap dn udf", 32'(w_udf), 32'h4);
      check("w wrap dn ovf", 32'(w_ovf), 32'h4);
      w_idle();
      w_ld = 1'b1; w_ld_sel = 2'd3; w_ld_val = 5'd5;
      w_rd_sel = 2'd2;
      step();
      check("w ld oor ignored", 32'(w_cnt), {17'd0, 5'd31, 5'd0, 5'd0});
      check("w rd ch2", 32'(w_rd_data), 32'd31);
      w_idle();
      w_rd_sel = 2'd3;
      step();
      check("w rd oor", 32'(w_rd_data), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
